// File: rtl/intdiv_sched.sv
// Two-requester round-robin front-end sharing one combinational signed divider.
// Operands are registered, held for a settle window, then the result is captured.

module intdiv_intdiv #(
  parameter int N = 5
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  output logic [N-1:0] z_o,
  output logic [N-1:0] r_o
);

  logic [N-1:0] ax, ay, q;
  logic [N:0]   rem;

  // Restoring division on magnitudes; signs re-applied afterwards
  always_comb begin
    ax  = x_i[N-1] ? (~x_i + 1'b1) : x_i;
    ay  = y_i[N-1] ? (~y_i + 1'b1) : y_i;
    rem = '0;
    q   = '0;
    for (int i = N-1; i >= 0; i--) begin
      rem = {rem[N-1:0], ax[i]};
      if (rem >= {1'b0, ay}) begin
        rem  = rem - {1'b0, ay};
        q[i] = 1'b1;
      end
    end
    z_o = (x_i[N-1] ^ y_i[N-1]) ? (~q + 1'b1) : q;
    r_o = x_i[N-1] ? (~rem[N-1:0] + 1'b1) : rem[N-1:0];
  end

endmodule

module intdiv_sched #(
  parameter int N             = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_x,
  input  logic [N-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_x,
  input  logic [N-1:0] req1_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_z,
  output logic [N-1:0] out_r,
  output logic         out_id,
  output logic         out_dz,
  output logic         out_ovf,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_t;

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [3:0]   CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t       state_q, state_d;
  logic         rr_q, rr_d;
  logic [N-1:0] x_q, x_d, y_q, y_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [N-1:0] z_q, z_d, r_q, r_d;
  logic         id_q, id_d, dz_q, dz_d, ovf_q, ovf_d;

  logic         gnt0, gnt1;
  logic [N-1:0] sel_x, sel_y;
  logic [N-1:0] core_z, core_r;

  intdiv_intdiv #(.N(N)) u_core (
    .x_i (x_q),
    .y_i (y_q),
    .z_o (core_z),
    .r_o (core_r)
  );

  assign gnt0  = req0_valid & (~req1_valid | ~rr_q);
  assign gnt1  = req1_valid & (~req0_valid |  rr_q);
  assign sel_x = gnt1 ? req1_x : req0_x;
  assign sel_y = gnt1 ? req1_y : req0_y;

  assign req0_ready = rst_n & (state_q == S_IDLE) & gnt0;
  assign req1_ready = rst_n & (state_q == S_IDLE) & gnt1;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_z      = z_q;
  assign out_r      = r_q;
  assign out_id     = id_q;
  assign out_dz     = dz_q;
  assign out_ovf    = ovf_q;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    r_d     = r_q;
    id_d    = id_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt0 | gnt1) begin
          x_d  = sel_x;
          y_d  = sel_y;
          id_d = gnt1;
          rr_d = gnt0;
          if (sel_y == '0) begin
            state_d = S_DONE;
            z_d     = '0;
            r_d     = sel_x;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
          end else if (sel_x == MIN_NEG && sel_y == '1) begin
            state_d = S_DONE;
            z_d     = sel_x;
            r_d     = '0;
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          z_d     = core_z;
          r_d     = core_r;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      r_q     <= '0;
      id_q    <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      r_q     <= r_d;
      id_q    <= id_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
